// File: rtl/mult16_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult16_seq_ctrl                                                          |
// | 16x16 signed multiply sequenced over a shared external 8x8 multiplier.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mult16_seq_ctrl #(
  parameter bit ZERO_SKIP = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic signed [31:0] o_z,
  output logic               o_range_err,
  output logic signed [7:0]  o_mA,
  output logic signed [7:0]  o_mB,
  input  logic signed [15:0] i_mP,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [31:0] r_acc;
  logic        r_range_err;

  logic [7:0]  w_la;
  logic [7:0]  w_ha;
  logic [7:0]  w_lb;
  logic [7:0]  w_hb;
  logic [31:0] w_prod_sx;
  logic [31:0] w_acc_add;
  logic        w_accept;
  logic        w_zero_op;

  // Low halves are zero-extended so only the high halves carry the sign.
  assign w_la      = {1'b0, r_a[6:0]};
  assign w_ha      = r_a[14:7];
  assign w_lb      = {1'b0, r_b[6:0]};
  assign w_hb      = r_b[14:7];
  assign w_prod_sx = {{16{i_mP[15]}}, i_mP};
  assign w_accept  = i_valid && (r_state == IDLE);
  assign w_zero_op = ZERO_SKIP && ((r_a == 16'd0) || (r_b == 16'd0));

  always_comb begin
    w_state_nxt = r_state;
    o_mA        = '0;
    o_mB        = '0;
    w_acc_add   = '0;
    case (r_state)
      IDLE: begin
        if (i_valid) w_state_nxt = S0;
      end
      S0: begin
        if (w_zero_op) begin
          w_state_nxt = DONE;
        end else begin
          o_mA        = w_la;
          o_mB        = w_lb;
          w_acc_add   = w_prod_sx;
          w_state_nxt = S1;
        end
      end
      S1: begin
        o_mA        = w_la;
        o_mB        = w_hb;
        w_acc_add   = w_prod_sx << 7;
        w_state_nxt = S2;
      end
      S2: begin
        o_mA        = w_ha;
        o_mB        = w_lb;
        w_acc_add   = w_prod_sx << 7;
        w_state_nxt = S3;
      end
      S3: begin
        o_mA        = w_ha;
        o_mB        = w_hb;
        w_acc_add   = w_prod_sx << 14;
        w_state_nxt = DONE;
      end
      DONE: begin
        if (i_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_range_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a         <= i_a;
        r_b         <= i_b;
        r_acc       <= '0;
        r_range_err <= (i_a[15] ^ i_a[14]) | (i_b[15] ^ i_b[14]);
      end else begin
        r_acc <= r_acc + w_acc_add;
      end
    end
  end

  assign o_z         = r_acc;
  assign o_range_err = r_range_err;
  assign o_ready     = (r_state == IDLE);
  assign o_valid     = (r_state == DONE);
  assign o_busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult16_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mult16_seq_ctrl                                                       |
// | Self-checking bench: vector table, scoreboard and corner sequences.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mult16_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v0 = 1'b0;
  logic v1 = 1'b0;
  logic rdy = 1'b1;
  logic signed [15:0] a = '0;
  logic signed [15:0] b = '0;

  logic ready0, ov0, err0, busy0;
  logic signed [31:0] z0;
  logic signed [7:0]  ma0, mb0;
  logic signed [15:0] mp0;
  logic ready1, ov1, err1, busy1;
  logic signed [31:0] z1;
  logic signed [7:0]  ma1, mb1;
  logic signed [15:0] mp1;

  assign mp0 = ma0 * mb0;
  assign mp1 = ma1 * mb1;

  always #5 clk = ~clk;

  mult16_seq_ctrl #(.ZERO_SKIP(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .o_ready(ready0),
    .i_a(a), .i_b(b), .o_valid(ov0), .i_ready(rdy), .o_z(z0),
    .o_range_err(err0), .o_mA(ma0), .o_mB(mb0), .i_mP(mp0), .o_busy(busy0)
  );

  mult16_seq_ctrl #(.ZERO_SKIP(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(ready1),
    .i_a(a), .i_b(b), .o_valid(ov1), .i_ready(rdy), .o_z(z1),
    .o_range_err(err1), .o_mA(ma1), .o_mB(mb1), .i_mP(mp1), .o_busy(busy1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] z;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] z;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] model_z(input logic [15:0] x, input logic [15:0] y);
    logic signed [14:0] sx;
    logic signed [14:0] sy;
    sx = x[14:0];
    sy = y[14:0];
    return 32'(int'(sx) * int'(sy));
  endfunction

  function automatic logic model_err(input logic [15:0] x, input logic [15:0] y);
    return (x[15] ^ x[14]) | (y[15] ^ y[14]);
  endfunction

  // Result monitor: a handshake happens on the edge after a cycle with both valid and ready.
  always @(negedge clk) begin
    if (rst_n && ov0 && rdy) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: got z=%0h with nothing expected", z0);
      end else begin
        exp_t e;
        n_pass++;
        e = sb.pop_front();
        chk("sb_z", z0, e.z);
        chk("sb_err", {31'd0, err0}, {31'd0, e.err});
      end
    end
  end

  task automatic accept0(input logic [15:0] ta, input logic [15:0] tb);
    int n = 0;
    while (!ready0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("ready_timeout", {31'd0, ready0}, 32'd1);
    a = ta; b = tb; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_valid0(output int n);
    n = 0;
    while (ov0 !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    vec_t tbl[13];
    logic [7:0] exp_ma[4];
    logic [7:0] exp_mb[4];
    int n;
    int prev;
    int good;
    logic [31:0] zs;
    logic es;

    tbl[0] = '{16'hC000, 16'h3FFF, 32'hF000_4000, 1'b0};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 32'd1,         1'b0};
    tbl[2] = '{16'h8000, 16'h0002, 32'd0,         1'b1};
    tbl[3] = '{16'h0007, 16'h0009, 32'd63,        1'b0};
    tbl[4] = '{16'h3FFF, 16'h3FFF, 32'h0FFF_8001, 1'b0};
    tbl[5] = '{16'hC000, 16'hC000, 32'h1000_0000, 1'b0};
    tbl[6] = '{16'h0064, 16'hFF38, 32'hFFFF_B1E0, 1'b0};
    tbl[7] = '{16'h7FFF, 16'h0001, 32'hFFFF_FFFF, 1'b1};
    tbl[8] = '{16'h1234, 16'hEDCC, 32'hFEB4_A570, 1'b0};
    for (int i = 9; i < 13; i++) begin
      tbl[i].a   = 16'($urandom);
      tbl[i].b   = 16'($urandom);
      tbl[i].z   = model_z(tbl[i].a, tbl[i].b);
      tbl[i].err = model_err(tbl[i].a, tbl[i].b);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_valid", {31'd0, ov0}, 32'd0);
    chk("rst_z", z0, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_mAB", {16'd0, ma0, mb0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 3*5 with step-by-step multiplier operands
    exp_ma = '{8'd3, 8'd3, 8'd0, 8'd0};
    exp_mb = '{8'd5, 8'd0, 8'd5, 8'd0};
    sb.push_back('{32'd15, 1'b0});
    accept0(16'd3, 16'd5);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("basic_mA_s%0d", s), {24'd0, ma0}, {24'd0, exp_ma[s]});
      chk($sformatf("basic_mB_s%0d", s), {24'd0, mb0}, {24'd0, exp_mb[s]});
      chk($sformatf("basic_valid_s%0d", s), {31'd0, ov0}, 32'd0);
      chk($sformatf("basic_busy_s%0d", s), {31'd0, busy0}, 32'd1);
      @(posedge clk); #1;
    end
    chk("basic_valid_done", {31'd0, ov0}, 32'd1);
    chk("basic_z", z0, 32'd15);
    chk("basic_done_mAB", {16'd0, ma0, mb0}, 32'd0);
    @(posedge clk); #1;

    // Table vectors, issued back to back
    prev = 0;
    for (int i = 0; i < 13; i++) begin
      sb.push_back('{tbl[i].z, tbl[i].err});
      accept0(tbl[i].a, tbl[i].b);
      if (i > 0) chk("throughput", acc_cyc - prev, 32'd6);
      prev = acc_cyc;
    end
    wait_valid0(n);
    chk("table_last_valid", {31'd0, ov0}, 32'd1);
    @(posedge clk); #1;

    // Backpressure in DONE
    rdy = 1'b0;
    sb.push_back('{model_z(16'd123, 16'hFFD3), model_err(16'd123, 16'hFFD3)});
    accept0(16'd123, 16'hFFD3);
    wait_valid0(n);
    chk("bp_latency", n, 32'd4);
    zs = z0;
    es = err0;
    good = 0;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = 16'($urandom); v0 = 1'b1;
      @(posedge clk); #1;
      if (ov0 === 1'b1 && z0 === zs && err0 === es && ready0 === 1'b0) good++;
    end
    chk("bp_stable_cycles", good, 32'd10);
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_to_idle_ready", {31'd0, ready0}, 32'd1);
    chk("bp_to_idle_valid", {31'd0, ov0}, 32'd0);
    v0 = 1'b0;
    @(posedge clk); #1;
    chk("bp_no_accept_busy", {31'd0, busy0}, 32'd0);
    chk("z_retained", z0, zs);

    // Reset during S2 abandons the operation
    accept0(16'h800B, 16'd13);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", {31'd0, ready0}, 32'd1);
    chk("midrst_busy", {31'd0, busy0}, 32'd0);
    chk("midrst_valid", {31'd0, ov0}, 32'd0);
    chk("midrst_z", z0, 32'd0);
    chk("midrst_err", {31'd0, err0}, 32'd0);
    chk("midrst_mAB", {16'd0, ma0, mb0}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    sb.push_back('{32'd63, 1'b0});
    accept0(16'd7, 16'd9);
    wait_valid0(n);
    chk("post_rst_latency", n, 32'd4);
    @(posedge clk); #1;

    // Zero operand without skip: four steps still run
    sb.push_back('{32'd0, 1'b0});
    accept0(16'd0, 16'd1234);
    wait_valid0(n);
    chk("noskip_latency", n, 32'd4);
    chk("noskip_z", z0, 32'd0);
    @(posedge clk); #1;

    // Zero operand with skip on the second instance
    chk("skip_ready", {31'd0, ready1}, 32'd1);
    a = 16'd0; b = 16'd1234; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("skip_s0_mAB", {16'd0, ma1, mb1}, 32'd0);
    chk("skip_s0_valid", {31'd0, ov1}, 32'd0);
    chk("skip_s0_busy", {31'd0, busy1}, 32'd1);
    @(posedge clk); #1;
    chk("skip_valid", {31'd0, ov1}, 32'd1);
    chk("skip_z", z1, 32'd0);
    chk("skip_done_mAB", {16'd0, ma1, mb1}, 32'd0);
    @(posedge clk); #1;
    chk("skip_idle", {31'd0, ready1}, 32'd1);

    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
